vga_mem_arbiter: RTL

VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

---
 rtl/vga_mem_pkg.sv | 23 ++
 rtl/vga_mem_arbiter_if.sv | 42 ++++
 rtl/vga_mem_starve_cnt.sv | 36 +++
 rtl/vga_mem_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/vga_mem_pkg.sv
// Shared definitions for the VGA / CPU frame-memory arbiter.
// Contents: default bus widths, default CPU starvation limit, FSM state
// encoding and the grant-owner encoding used by the datapath.
package vga_mem_pkg;

  localparam int ADDR_W_DEF       = 15;
  localparam int DATA_W_DEF       = 16;
  localparam int STARVE_LIMIT_DEF = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    VGA_ISSUE = 2'd1,
    CPU_ISSUE = 2'd2,
    RESP      = 2'd3
  } arb_state_e;

  // Which requester owns the access currently in flight.
  typedef enum logic {
    SEL_VGA = 1'b0,
    SEL_CPU = 1'b1
  } grant_e;

endpackage

// File: rtl/vga_mem_arbiter_if.sv
// Bus bundle between the pixel generator, the CPU, the arbiter and the
// single-port frame RAM.
// Modports:
//   slave  - arbiter view: takes requests and mem_rdata, drives responses
//            and the RAM command signals.
//   master - environment view: drives requests and mem_rdata, observes the
//            rest.
interface vga_mem_arbiter_if
  import vga_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_data;
  logic              vga_valid;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output vga_data, vga_valid, cpu_rdata, cpu_ack, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  vga_data, vga_valid, cpu_rdata, cpu_ack, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/vga_mem_starve_cnt.sv
// Saturating CPU starvation counter.
// Ports:
//   clk, reset - system clock, asynchronous active-high reset
//   inc        - CPU is requesting this cycle
//   clr        - CPU granted / being served / not requesting: restart count
//   full       - count has reached LIMIT (CPU must win the next decision)
module vga_mem_starve_cnt #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic full
);

  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] MAX = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign full = (cnt == MAX);

endmodule

// File: rtl/vga_mem_arbiter.sv
// Two-requester arbiter for a synchronous single-port frame RAM.
// VGA has priority; the CPU is forced through once it has waited
// STARVE_LIMIT cycles. Each access is IDLE -> ISSUE -> RESP, so the
// response pulse appears two clock edges after the granting edge.
// Ports:
//   clk, reset - system clock, asynchronous active-high reset
//   bus        - slave modport of vga_mem_arbiter_if (requests, responses,
//                RAM command and read data)
module vga_mem_arbiter
  import vga_mem_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  vga_mem_arbiter_if.slave   bus
);

  arb_state_e        state, next_state;
  grant_e            sel;
  logic              cpu_we_q;
  logic              vga_grant, cpu_grant;
  logic              cpu_busy, starve_clr, starve_full;

  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] vga_data_q, cpu_rdata_q;
  logic              vga_valid_q, cpu_ack_q;

  // A CPU access in flight is not waiting, so the counter stays cleared
  // until the CPU is actually back in line.
  assign cpu_busy   = (state == CPU_ISSUE) || ((state == RESP) && (sel == SEL_CPU));
  assign starve_clr = !bus.cpu_req || cpu_grant || cpu_busy;

  vga_mem_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (bus.cpu_req),
    .clr   (starve_clr),
    .full  (starve_full)
  );

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    vga_grant  = 1'b0;
    cpu_grant  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.cpu_req && starve_full) begin
          cpu_grant  = 1'b1;
          next_state = CPU_ISSUE;
        end else if (bus.vga_req) begin
          vga_grant  = 1'b1;
          next_state = VGA_ISSUE;
        end else if (bus.cpu_req) begin
          cpu_grant  = 1'b1;
          next_state = CPU_ISSUE;
        end
      end
      VGA_ISSUE: next_state = RESP;
      CPU_ISSUE: next_state = RESP;
      RESP:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Requester fields are captured into the RAM command registers on the
  // granting edge, so they are stable for the ISSUE cycle and later input
  // changes cannot disturb the access. mem_we is a one-cycle pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel         <= SEL_VGA;
      cpu_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      vga_data_q  <= '0;
      cpu_rdata_q <= '0;
      vga_valid_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
    end else begin
      mem_we_q    <= 1'b0;
      vga_valid_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
      if (vga_grant) begin
        sel        <= SEL_VGA;
        mem_addr_q <= bus.vga_addr;
      end
      if (cpu_grant) begin
        sel         <= SEL_CPU;
        cpu_we_q    <= bus.cpu_we;
        mem_addr_q  <= bus.cpu_addr;
        mem_wdata_q <= bus.cpu_wdata;
        mem_we_q    <= bus.cpu_we;
      end
      if (state == RESP) begin
        if (sel == SEL_VGA) begin
          vga_data_q  <= bus.mem_rdata;
          vga_valid_q <= 1'b1;
        end else begin
          cpu_ack_q <= 1'b1;
          if (!cpu_we_q) cpu_rdata_q <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.vga_data  = vga_data_q;
  assign bus.vga_valid = vga_valid_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_ack   = cpu_ack_q;

endmodule
